c5_mem_resp: RTL and testbench

- Memory-side responder for the c5_cpu bus: receives the CPU's address, byte-enable and write data, and returns read data and the pause (stall) signal.
- Contains an inferred synchronous word RAM with programmable wait states, plus a small register window for GPIO out, GPIO in and the LED.
- Sits between c5_cpu and the soc top-level pins.

---
 rtl/c5_mem_resp.sv | 144 ++++++++++++++
 tb/tb_c5_mem_resp.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c5_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : c5_mem_resp
// Brief    : c5_cpu memory responder with a wait-stated synchronous word RAM
//            and a GPIO_OUT / GPIO_IN / LED / ERR register window.
//            Define C5_MEM_ERR_EN to build the sticky unmapped-access flag.
// Revision : 1.0 - initial release
// ============================================================================
module c5_mem_resp #(
    parameter int          RAM_AW      = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] GPIO_RST    = 32'h0000_0000
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [29:0] I_address_next,
    input  logic [3:0]  I_byte_we_next,
    input  logic [29:0] I_address,
    input  logic [3:0]  I_byte_we,
    input  logic [31:0] I_data_w,
    output logic [31:0] O_data_r,
    output logic        O_mem_pause,
    input  logic [31:0] I_gpio_in,
    output logic [31:0] O_gpio_out,
    output logic        O_led,
    output logic        O_bus_err
);

    localparam logic [3:0] c_WAIT      = 4'(WAIT_STATES);
    localparam logic [3:0] c_RGN_RAM   = 4'h0;
    localparam logic [3:0] c_RGN_REG   = 4'h2;
    localparam logic [1:0] c_REG_GPO   = 2'd0;
    localparam logic [1:0] c_REG_GPI   = 2'd1;
    localparam logic [1:0] c_REG_LED   = 2'd2;

    logic              w_ram_sel;
    logic              w_reg_sel;
    logic              w_unmapped;
    logic              w_pause;
    logic              w_commit;
    logic              w_ram_we;
    logic [RAM_AW-1:0] w_idx;
    logic [RAM_AW-1:0] w_rd_idx;
    logic [RAM_AW-1:0] r_rd_idx;
    logic [3:0]        r_cnt;
    logic              r_run;
    logic [31:0]       r_mem [0:(2**RAM_AW)-1];
    logic [31:0]       r_ram_q;
    logic [31:0]       r_gpio_out;
    logic [31:0]       r_gin_s1;
    logic [31:0]       r_gin_s2;
    logic              r_led;
    logic              w_err_bit;
    logic [31:0]       w_reg_rd;
    logic              w_unused;

    assign w_ram_sel  = (I_address[29:26] == c_RGN_RAM);
    assign w_reg_sel  = (I_address[29:26] == c_RGN_REG);
    assign w_unmapped = !w_ram_sel && !w_reg_sel;
    assign w_idx      = I_address[RAM_AW-1:0];

    assign w_pause    = w_ram_sel && (r_cnt != c_WAIT) && r_run;
    assign w_commit   = !w_pause && (I_byte_we != 4'h0);
    assign w_ram_we   = w_commit && w_ram_sel;

    // While stalled the RAM keeps re-reading the held index so late writes are seen.
    assign w_rd_idx   = w_pause ? r_rd_idx : I_address_next[RAM_AW-1:0];

    always_ff @(posedge I_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ram_we && I_byte_we[i])
                r_mem[w_idx][8*i +: 8] <= I_data_w[8*i +: 8];
            // Write-first on a same-index collision keeps zero-wait read-after-write coherent
            if (w_ram_we && I_byte_we[i] && (w_idx == w_rd_idx))
                r_ram_q[8*i +: 8] <= I_data_w[8*i +: 8];
            else
                r_ram_q[8*i +: 8] <= r_mem[w_rd_idx][8*i +: 8];
        end
        r_rd_idx <= w_rd_idx;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_cnt      <= 4'd0;
            r_run      <= 1'b0;
            r_gin_s1   <= 32'h0;
            r_gin_s2   <= 32'h0;
            r_gpio_out <= GPIO_RST;
            r_led      <= 1'b0;
        end else begin
            r_run    <= 1'b1;
            r_cnt    <= w_pause ? (r_cnt + 4'd1) : 4'd0;
            r_gin_s1 <= I_gpio_in;
            r_gin_s2 <= r_gin_s1;
            if (w_commit && w_reg_sel) begin
                if (I_address[1:0] == c_REG_GPO) begin
                    for (int i = 0; i < 4; i++)
                        if (I_byte_we[i])
                            r_gpio_out[8*i +: 8] <= I_data_w[8*i +: 8];
                end
                if ((I_address[1:0] == c_REG_LED) && I_byte_we[0])
                    r_led <= I_data_w[0];
            end
        end
    end

`ifdef C5_MEM_ERR_EN
    logic r_bus_err;

    // Set has priority over a coincident clear.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            r_bus_err <= 1'b0;
        else if (w_unmapped)
            r_bus_err <= 1'b1;
        else if (w_commit && w_reg_sel && (I_address[1:0] == 2'd3) && I_byte_we[0] && I_data_w[0])
            r_bus_err <= 1'b0;
    end

    assign w_err_bit = r_bus_err;
`else
    assign w_err_bit = 1'b0;
`endif

    always_comb begin
        w_reg_rd = 32'h0;
        case (I_address[1:0])
            c_REG_GPO: w_reg_rd = r_gpio_out;
            c_REG_GPI: w_reg_rd = r_gin_s2;
            c_REG_LED: w_reg_rd = {31'b0, r_led};
            default:   w_reg_rd = {31'b0, w_err_bit};
        endcase
    end

    assign O_data_r    = w_ram_sel ? r_ram_q : (w_reg_sel ? w_reg_rd : 32'h0);
    assign O_mem_pause = w_pause;
    assign O_gpio_out  = r_gpio_out;
    assign O_led       = r_led;
    assign O_bus_err   = w_err_bit;

    assign w_unused = ^{I_byte_we_next, I_address_next[29:RAM_AW], I_address[25:RAM_AW], w_unmapped};

endmodule
`default_nettype wire

// File: tb/tb_c5_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_c5_mem_resp
// Brief    : Self-checking bench for c5_mem_resp: directed and random bus
//            transactions checked against a transaction-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c5_mem_resp;

    localparam int          RAM_AW   = 10;
    localparam int          WS       = 3;
    localparam logic [31:0] GPIO_RST = 32'hC0DE_0F0F;
    localparam int          NRAND    = 300;
`ifdef C5_MEM_ERR_EN
    localparam bit          ERR_EN   = 1'b1;
`else
    localparam bit          ERR_EN   = 1'b0;
`endif

    logic        I_clk = 1'b0;
    logic        I_rst_n;
    logic [29:0] I_address_next;
    logic [3:0]  I_byte_we_next;
    logic [29:0] I_address;
    logic [3:0]  I_byte_we;
    logic [31:0] I_data_w;
    logic [31:0] O_data_r;
    logic        O_mem_pause;
    logic [31:0] I_gpio_in;
    logic [31:0] O_gpio_out;
    logic        O_led;
    logic        O_bus_err;

    c5_mem_resp #(
        .RAM_AW      (RAM_AW),
        .WAIT_STATES (WS),
        .GPIO_RST    (GPIO_RST)
    ) u_dut (
        .I_clk          (I_clk),
        .I_rst_n        (I_rst_n),
        .I_address_next (I_address_next),
        .I_byte_we_next (I_byte_we_next),
        .I_address      (I_address),
        .I_byte_we      (I_byte_we),
        .I_data_w       (I_data_w),
        .O_data_r       (O_data_r),
        .O_mem_pause    (O_mem_pause),
        .I_gpio_in      (I_gpio_in),
        .O_gpio_out     (O_gpio_out),
        .O_led          (O_led),
        .O_bus_err      (O_bus_err)
    );

    always #5 I_clk = ~I_clk;

    typedef struct packed {
        logic [29:0] a;
        logic [3:0]  we;
        logic [31:0] d;
    } txn_t;

    txn_t        q[$];
    txn_t        drv_cur;
    bit          drv_from_q;
    logic [31:0] m_ram   [0:(2**RAM_AW)-1];
    bit          m_known [0:(2**RAM_AW)-1];
    logic [31:0] m_gpio;
    logic        m_led;
    logic        m_err;
    bit          m_run;
    int          waited;
    logic [31:0] gh0, gh1, gh2;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] ba, input logic [3:0] we, input logic [31:0] d);
        txn_t t;
        t.a  = ba[31:2];
        t.we = we;
        t.d  = d;
        return t;
    endfunction

    function automatic txn_t idle();
        return mk(32'h2000_0004, 4'h0, 32'h0);
    endfunction

    function automatic bit is_ram(input txn_t t);
        return t.a[29:26] == 4'h0;
    endfunction

    function automatic bit is_reg(input txn_t t);
        return t.a[29:26] == 4'h2;
    endfunction

    function automatic logic [31:0] exp_rd(input txn_t t, output bit valid);
        int idx;
        valid = 1'b1;
        if (is_ram(t)) begin
            idx   = int'(t.a[RAM_AW-1:0]);
            valid = m_known[idx];
            return m_ram[idx];
        end
        if (is_reg(t)) begin
            case (t.a[1:0])
                2'd0:    return m_gpio;
                2'd1:    return gh2;
                2'd2:    return {31'b0, m_led};
                default: return {31'b0, m_err};
            endcase
        end
        return 32'h0;
    endfunction

    task automatic commit(input txn_t t);
        int idx;
        if (is_ram(t)) begin
            idx = int'(t.a[RAM_AW-1:0]);
            for (int i = 0; i < 4; i++)
                if (t.we[i]) m_ram[idx][8*i +: 8] = t.d[8*i +: 8];
            if (t.we == 4'hF) m_known[idx] = 1'b1;
        end else if (is_reg(t)) begin
            if (t.a[1:0] == 2'd0) begin
                for (int i = 0; i < 4; i++)
                    if (t.we[i]) m_gpio[8*i +: 8] = t.d[8*i +: 8];
            end else if (t.a[1:0] == 2'd2 && t.we[0]) begin
                m_led = t.d[0];
            end else if (t.a[1:0] == 2'd3 && t.we[0] && t.d[0]) begin
                m_err = 1'b0;
            end
        end else if (ERR_EN) begin
            m_err = 1'b1;
        end
    endtask

    function automatic txn_t rnd_txn();
        int          r;
        logic [31:0] ba;
        logic [3:0]  we;
        r  = $urandom_range(0, 99);
        ba = $urandom;
        if (r < 55) begin
            ba[31:28] = 4'h0;
            ba[RAM_AW+1:2] = '0;
            ba[5:2] = 4'($urandom_range(0, 15));
        end else if (r < 88) begin
            ba[31:28] = 4'h2;
        end else begin
            ba[31:28] = ($urandom_range(0, 3) == 0) ? 4'h1 : 4'($urandom_range(3, 15));
        end
        ba[1:0] = 2'b00;
        we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        return mk(ba, we, $urandom);
    endfunction

    task automatic drive();
        txn_t nx;
        if (q.size() > 0) begin
            drv_cur    = q[0];
            drv_from_q = 1'b1;
        end else begin
            drv_cur    = idle();
            drv_from_q = 1'b0;
        end
        nx = (q.size() > 1) ? q[1] : idle();
        I_address      = drv_cur.a;
        I_byte_we      = drv_cur.we;
        I_data_w       = drv_cur.d;
        I_address_next = nx.a;
        I_byte_we_next = nx.we;
    endtask

    task automatic run_cycle();
        bit          exp_pause;
        bit          valid;
        logic [31:0] ev;
        @(negedge I_clk);
        exp_pause = is_ram(drv_cur) && m_run && (waited < WS);
        check("pause",    {31'b0, O_mem_pause}, {31'b0, exp_pause});
        check("gpio_out", O_gpio_out, m_gpio);
        check("led",      {31'b0, O_led}, {31'b0, m_led});
        check("bus_err",  {31'b0, O_bus_err}, {31'b0, m_err});
        if (!exp_pause && drv_cur.we == 4'h0) begin
            ev = exp_rd(drv_cur, valid);
            if (valid) check("data_r", O_data_r, ev);
        end
        @(posedge I_clk);
        if (exp_pause) begin
            waited++;
        end else begin
            commit(drv_cur);
            waited = 0;
            if (drv_from_q) void'(q.pop_front());
        end
        m_run = 1'b1;
        gh2   = gh1;
        gh1   = gh0;
        #1;
        gh0       = $urandom;
        I_gpio_in = gh0;
        drive();
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 20000) begin
            run_cycle();
            guard++;
        end
        check("drain_left", q.size(), 32'h0);
    endtask

    task automatic do_reset(input int ncyc, input bit drop);
        I_rst_n   = 1'b0;
        I_byte_we = 4'h0;
        if (drop && drv_from_q) void'(q.pop_front());
        m_gpio = GPIO_RST;
        m_led  = 1'b0;
        m_err  = 1'b0;
        m_run  = 1'b0;
        waited = 0;
        gh1    = 32'h0;
        gh2    = 32'h0;
        #1;
        check("rst_pause",    {31'b0, O_mem_pause}, 32'h0);
        check("rst_gpio_out", O_gpio_out, m_gpio);
        check("rst_led",      {31'b0, O_led}, {31'b0, m_led});
        check("rst_bus_err",  {31'b0, O_bus_err}, {31'b0, m_err});
        repeat (ncyc) begin
            @(posedge I_clk);
            gh1 = 32'h0;
            gh2 = 32'h0;
        end
        #1;
        q.push_front(idle());
        drive();
        I_rst_n = 1'b1;
    endtask

    initial begin
        I_rst_n        = 1'b0;
        I_address      = 30'h0;
        I_address_next = 30'h0;
        I_byte_we      = 4'h0;
        I_byte_we_next = 4'h0;
        I_data_w       = 32'h0;
        drv_cur        = mk(32'h0, 4'h0, 32'h0);
        drv_from_q     = 1'b0;
        gh0            = $urandom;
        I_gpio_in      = gh0;
        for (int i = 0; i < 2**RAM_AW; i++) m_known[i] = 1'b0;
        @(posedge I_clk);
        #1;

        // Directed: word write/read, byte lane merge, GPIO, LED, ERR window
        q.push_back(mk(32'h0000_0010, 4'hF, 32'hDEAD_BEEF));
        q.push_back(mk(32'h0000_0010, 4'h0, 32'h0));
        q.push_back(mk(32'h0000_0010, 4'b0010, 32'h0000_5500));
        q.push_back(mk(32'h0000_0010, 4'h0, 32'h0));
        q.push_back(mk(32'h2000_0000, 4'hF, 32'h1234_5678));
        q.push_back(mk(32'h2000_0004, 4'h0, 32'h0));
        q.push_back(mk(32'h2000_0008, 4'h1, 32'h0000_0001));
        q.push_back(mk(32'h4000_0000, 4'h0, 32'h0));
        q.push_back(mk(32'h2000_000C, 4'h0, 32'h0));
        q.push_back(mk(32'h2000_000C, 4'h1, 32'h0000_0001));
        q.push_back(mk(32'h2000_000C, 4'h0, 32'h0));
        for (int w = 0; w < 16; w++)
            q.push_back(mk(32'(w * 4), 4'hF, $urandom));
        for (int w = 0; w < 16; w++)
            q.push_back(mk(32'(w * 4), 4'h0, 32'h0));
        do_reset(3, 1'b0);
        drain();

        // Random mix of RAM (with aliasing), register and unmapped accesses
        q.push_back(idle());
        for (int n = 0; n < NRAND; n++) q.push_back(rnd_txn());
        drain();

        // Reset in the middle of a waited write: the write must be dropped
        q.push_back(idle());
        q.push_back(mk(32'h0000_0020, 4'hF, 32'h0000_0001));
        q.push_back(mk(32'h0000_0020, 4'h0, 32'h0));
        run_cycle();
        run_cycle();
        run_cycle();
        do_reset(2, 1'b1);
        drain();
        repeat (4) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
